// File: rtl/imem_loader.sv
// Byte-serial program loader: assembles big-endian 32-bit words from a valid/ready
// stream and writes them to instruction memory, holding the CPU until the image is in.
module imem_loader #(
  parameter int unsigned              ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
  parameter int unsigned              MAX_WORDS  = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  LOAD_START,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic                  IMEM_WRITE,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [31:0]           IMEM_WDATA,
  output logic                  CPU_HOLD,
  output logic                  LOAD_DONE,
  output logic                  LOAD_ERROR,
  output logic [15:0]           WORDS_LOADED
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, B0, B1, B2, B3, WRITE, DONE
  } state_t;

  state_t                state;
  logic [15:0]           word_count;
  logic [15:0]           word_index;
  logic [23:0]           partial;
  logic                  accept;
  logic                  in_range;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign accept    = BYTE_VALID && BYTE_READY;
  assign in_range  = {16'd0, word_index} < MAX_WORDS;
  assign last_word = ({1'b0, word_index} + 17'd1) == {1'b0, word_count};
  // Byte address of the word in flight; wraps at ADDR_WIDTH like the PC does.
  assign word_addr = BASE_ADDR + ADDR_WIDTH'({word_index, 2'b00});

  // NOTE: every register here, outputs included, is assigned non-blocking so each
  // branch sees the pre-edge values no matter the statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      BYTE_READY   <= 1'b0;
      IMEM_WRITE   <= 1'b0;
      IMEM_ADDR    <= BASE_ADDR;
      IMEM_WDATA   <= '0;
      CPU_HOLD     <= 1'b1;
      LOAD_DONE    <= 1'b0;
      LOAD_ERROR   <= 1'b0;
      WORDS_LOADED <= '0;
      word_count   <= '0;
      word_index   <= '0;
      partial      <= '0;
    end else begin
      IMEM_WRITE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (LOAD_START) begin
            state        <= LEN_HI;
            BYTE_READY   <= 1'b1;
            CPU_HOLD     <= 1'b1;
            LOAD_DONE    <= 1'b0;
            LOAD_ERROR   <= 1'b0;
            WORDS_LOADED <= '0;
            word_index   <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            word_count[15:8] <= BYTE_IN;
            state            <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            word_count[7:0] <= BYTE_IN;
            if ({word_count[15:8], BYTE_IN} == 16'd0) begin
              state      <= DONE;
              BYTE_READY <= 1'b0;
              CPU_HOLD   <= 1'b0;
              LOAD_DONE  <= 1'b1;
            end else begin
              state <= B0;
            end
          end
        end
        B0: begin
          if (accept) begin
            partial[23:16] <= BYTE_IN;
            state          <= B1;
          end
        end
        B1: begin
          if (accept) begin
            partial[15:8] <= BYTE_IN;
            state         <= B2;
          end
        end
        B2: begin
          if (accept) begin
            partial[7:0] <= BYTE_IN;
            state        <= B3;
          end
        end
        B3: begin
          // The strobe is registered here so it is high during the WRITE cycle.
          if (accept) begin
            state      <= WRITE;
            BYTE_READY <= 1'b0;
            if (in_range) begin
              IMEM_WRITE   <= 1'b1;
              IMEM_ADDR    <= word_addr;
              IMEM_WDATA   <= {partial, BYTE_IN};
              WORDS_LOADED <= WORDS_LOADED + 16'd1;
            end else begin
              LOAD_ERROR <= 1'b1;
            end
          end
        end
        WRITE: begin
          word_index <= word_index + 16'd1;
          if (last_word) begin
            state     <= DONE;
            CPU_HOLD  <= 1'b0;
            LOAD_DONE <= 1'b1;
          end else begin
            state      <= B0;
            BYTE_READY <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          BYTE_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed images checked each cycle against a byte-counting
// model of the load protocol, plus literal expectations on the written words.
module tb_imem_loader;

  localparam int          MAXW = 2;
  localparam logic [63:0] BASE = 64'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        ready, wr, hold, done, err;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [15:0] loaded;

  imem_loader #(.ADDR_WIDTH(64), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLOCK(clk), .RESET(rst), .LOAD_START(start), .BYTE_IN(din), .BYTE_VALID(valid),
    .BYTE_READY(ready), .IMEM_WRITE(wr), .IMEM_ADDR(addr), .IMEM_WDATA(wdata),
    .CPU_HOLD(hold), .LOAD_DONE(done), .LOAD_ERROR(err), .WORDS_LOADED(loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol model: counts header bytes and word bytes instead of tracking states.
  bit          m_busy, m_in_write, m_hold, m_done, m_err, m_wr;
  int          m_loaded, m_index, m_n, m_len_bytes, m_word_bytes;
  logic [31:0] m_word, m_data;
  logic [63:0] m_addr;
  logic [95:0] wlog[$];

  task automatic model_reset();
    m_busy = 0; m_in_write = 0; m_hold = 1; m_done = 0; m_err = 0; m_wr = 0;
    m_loaded = 0; m_index = 0; m_n = 0; m_len_bytes = 0; m_word_bytes = 0;
    m_word = '0; m_data = '0; m_addr = BASE;
  endtask

  task automatic model_finish();
    m_busy = 0; m_hold = 0; m_done = 1;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [7:0] b);
    m_wr = 0;
    if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_hold = 1; m_done = 0; m_err = 0; m_loaded = 0;
        m_index = 0; m_n = 0; m_len_bytes = 0; m_word_bytes = 0;
      end
    end else if (m_in_write) begin
      m_in_write = 0;
      m_index++;
      if (m_index == m_n) model_finish();
    end else if (v) begin
      if (m_len_bytes < 2) begin
        m_n = m_n * 256 + int'(b);
        m_len_bytes++;
        if (m_len_bytes == 2 && m_n == 0) model_finish();
      end else begin
        m_word = {m_word[23:0], b};
        m_word_bytes++;
        if (m_word_bytes == 4) begin
          m_word_bytes = 0;
          m_in_write = 1;
          if (m_index < MAXW) begin
            m_wr = 1;
            m_addr = BASE + 64'(m_index) * 64'd4;
            m_data = m_word;
            m_loaded++;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  endtask

  // Compare process: outputs are checked mid-cycle, then the model advances with
  // the inputs that the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      check("byte_ready",   64'(ready),  64'(m_busy && !m_in_write));
      check("cpu_hold",     64'(hold),   64'(m_hold));
      check("load_done",    64'(done),   64'(m_done));
      check("load_error",   64'(err),    64'(m_err));
      check("words_loaded", 64'(loaded), 64'(m_loaded));
      check("imem_write",   64'(wr),     64'(m_wr));
      check("imem_addr",    addr,        m_addr);
      check("imem_wdata",   64'(wdata),  64'(m_data));
      if (wr === 1'b1) wlog.push_back({addr, wdata});
      if (!rst) model_step(start, valid, din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_valid);
    start = 1'b1; valid = with_valid; din = 8'h7F;
    tick();
    start = 1'b0; valid = 1'b0;
  endtask

  // Drives an image; toggle gives the VALID pattern 1,0,0,1,..., noise holds LOAD_START high.
  task automatic send(input logic [7:0] bytes[$], input bit toggle, input bit noise);
    int i = 0;
    int cyc = 0;
    bit v, acc;
    while (i < bytes.size() && cyc < 1000) begin
      v = toggle ? (cyc % 3 == 0) : 1'b1;
      valid = v;
      din = v ? bytes[i] : 8'hEE;
      start = noise;
      acc = v && m_busy && !m_in_write;
      tick();
      cyc++;
      if (acc) i++;
    end
    valid = 1'b0; start = 1'b0;
    check("bytes_sent", 64'(i), 64'(bytes.size()));
  endtask

  task automatic wait_done();
    int c = 0;
    while (m_busy && c < 200) begin
      tick();
      c++;
    end
    tick();
    check("load_done_level", 64'(done), 64'd1);
  endtask

  function automatic logic [95:0] log_at(input int i);
    if (i < wlog.size()) return wlog[i];
    return '1;
  endfunction

  task automatic check_write(input string name, input int i, input logic [63:0] a,
                             input logic [31:0] d);
    logic [95:0] e;
    e = log_at(i);
    check({name, "_addr"}, e[95:32], a);
    check({name, "_data"}, 64'(e[31:0]), 64'(d));
  endtask

  initial begin
    logic [7:0] img[$];

    repeat (3) tick();
    check("rst_hold",   64'(hold),   64'd1);
    check("rst_ready",  64'(ready),  64'd0);
    check("rst_write",  64'(wr),     64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    check("rst_addr",   addr,        64'd0);
    rst = 1'b0;
    tick();

    // Two-word image, back-to-back bytes.
    wlog.delete();
    pulse_start(1'b0);
    img = '{8'h00, 8'h02, 8'hF8, 8'h40, 8'h01, 8'h42, 8'hF8, 8'h40, 8'h11, 8'h43};
    send(img, 1'b0, 1'b0);
    wait_done();
    check("t1_writes", 64'(wlog.size()), 64'd2);
    check_write("t1_w0", 0, 64'd0, 32'hF8400142);
    check_write("t1_w1", 1, 64'd4, 32'hF8401143);
    check("t1_loaded", 64'(loaded), 64'd2);
    check("t1_hold",   64'(hold),   64'd0);
    check("t1_error",  64'(err),    64'd0);

    // Empty image: DONE right after the second length byte.
    wlog.delete();
    pulse_start(1'b0);
    img = '{8'h00, 8'h00};
    send(img, 1'b0, 1'b0);
    check("t2_hold", 64'(hold), 64'd0);
    check("t2_done", 64'(done), 64'd1);
    tick();
    check("t2_writes", 64'(wlog.size()), 64'd0);
    check("t2_loaded", 64'(loaded), 64'd0);

    // One word with a gappy VALID.
    wlog.delete();
    pulse_start(1'b0);
    img = '{8'h00, 8'h01, 8'hCB, 8'h02, 8'h00, 8'h64};
    send(img, 1'b1, 1'b0);
    wait_done();
    check("t3_writes", 64'(wlog.size()), 64'd1);
    check_write("t3_w0", 0, 64'd0, 32'hCB020064);

    // Overflow beyond MAX_WORDS, with LOAD_START held high throughout the load.
    wlog.delete();
    pulse_start(1'b0);
    img = '{8'h00, 8'h03, 8'h8B, 8'h02, 8'h00, 8'h65, 8'hB4, 8'h00, 8'h00, 8'h41,
            8'h14, 8'h00, 8'h00, 8'h03};
    send(img, 1'b0, 1'b1);
    wait_done();
    check("t4_writes", 64'(wlog.size()), 64'd2);
    check_write("t4_w0", 0, 64'd0, 32'h8B020065);
    check_write("t4_w1", 1, 64'd4, 32'hB4000041);
    check("t4_error",  64'(err),    64'd1);
    check("t4_loaded", 64'(loaded), 64'd2);

    // Reset in the middle of word 0, then a clean reload.
    wlog.delete();
    pulse_start(1'b0);
    img = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send(img, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("t5_hold",  64'(hold),  64'd1);
    check("t5_ready", 64'(ready), 64'd0);
    check("t5_done",  64'(done),  64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_write", 64'(wlog.size()), 64'd0);
    pulse_start(1'b0);
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send(img, 1'b0, 1'b0);
    wait_done();
    check("t5_writes", 64'(wlog.size()), 64'd1);
    check_write("t5_w0", 0, 64'd0, 32'h12345678);

    // Restart from DONE with a stray VALID in the start cycle.
    wlog.delete();
    pulse_start(1'b1);
    check("t6_hold", 64'(hold), 64'd1);
    check("t6_done", 64'(done), 64'd0);
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(img, 1'b0, 1'b0);
    wait_done();
    check("t6_writes", 64'(wlog.size()), 64'd1);
    check_write("t6_w0", 0, 64'd0, 32'hDEADBEEF);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory fetch interface. Receives a byte-serial program image over a valid/ready stream and assembles big-endian 32-bit instruction words. Writes each word into instruction memory at consecutive byte addresses (PC = 0, 4, 8, ...). Holds the CPU (CPU_HOLD) until the image is fully loaded, so the core's first fetch at PC 0 sees valid code.

Parameters:
ADDR_WIDTH, 64, width of IMEM_ADDR; matches the PC width.
BASE_ADDR, 0, byte address of the first word written.
MAX_WORDS, 16, instruction-memory capacity in 32-bit words; words at or beyond this index are not written.

Ports:
CLOCK  input  1  system clock; all state changes on posedge.
RESET  input  1  asynchronous, active-high reset.
LOAD_START  input  1  single-cycle pulse; begins a load from IDLE or DONE.
BYTE_IN  input  8  stream data byte.
BYTE_VALID  input  1  BYTE_IN is valid.
BYTE_READY  output  1  loader accepts a byte this cycle.
IMEM_WRITE  output  1  instruction-memory write strobe, one cycle per word.
IMEM_ADDR  output  ADDR_WIDTH  byte address of the word being written.
IMEM_WDATA  output  32  assembled instruction word.
CPU_HOLD  output  1  high = CPU must not advance PC.
LOAD_DONE  output  1  level; high while in DONE.
LOAD_ERROR  output  1  sticky; image exceeded MAX_WORDS.
WORDS_LOADED  output  16  number of words actually written in the current or last load.

Behaviour:
- Reset (async): state=IDLE; CPU_HOLD=1, BYTE_READY=0, IMEM_WRITE=0, IMEM_ADDR=BASE_ADDR, IMEM_WDATA=0, LOAD_DONE=0, LOAD_ERROR=0, WORDS_LOADED=0, internal word count and index=0.
- Byte transfer occurs only on a posedge with BYTE_VALID=1 and BYTE_READY=1. BYTE_READY is high only in LEN_HI, LEN_LO and B0..B3. It is a registered function of state and does not depend on BYTE_VALID.
- Image format: 16-bit word count N (big-endian, 2 bytes), then N words of 4 bytes each. The first byte of a word goes to bits [31:24]; the fourth goes to bits [7:0].
- States:
  - IDLE: LOAD_START -> LEN_HI. Clears LOAD_ERROR and WORDS_LOADED. CPU_HOLD stays 1.
  - LEN_HI: accept byte -> N[15:8] -> LEN_LO.
  - LEN_LO: accept byte -> N[7:0]. Go to DONE if N==0, else B0.
  - B0, B1, B2, B3: each accepts one byte into its lane. B3 accept -> WRITE.
  - WRITE (1 cycle):
    - If index < MAX_WORDS: IMEM_WRITE=1, IMEM_ADDR = BASE_ADDR + 4*index (truncated to ADDR_WIDTH), IMEM_WDATA = assembled word, WORDS_LOADED increments.
    - Otherwise: IMEM_WRITE=0 and LOAD_ERROR=1. The word is consumed and discarded.
    - Then index increments; go to DONE if index+1==N, else B0.
  - DONE: CPU_HOLD=0, LOAD_DONE=1, BYTE_READY=0. LOAD_START -> LEN_HI, which clears LOAD_DONE and LOAD_ERROR, zeroes WORDS_LOADED and index, and sets CPU_HOLD=1 in the same edge.
- Timing:
  - IMEM_WRITE asserts in the cycle after the 4th byte is accepted.
  - Minimum 5 cycles per word.
  - CPU_HOLD falls on the edge entering DONE.
- IMEM_ADDR and IMEM_WDATA hold their last values when IMEM_WRITE=0.
- LOAD_START is ignored in LEN_HI through WRITE.
- In IDLE or DONE, a BYTE_VALID in the same cycle as LOAD_START is not accepted (READY=0). Bytes are accepted from the next cycle.
- BYTE_VALID may drop at any time. State and partial word are held indefinitely; there is no timeout.
- Reset mid-load aborts immediately and returns to IDLE with CPU_HOLD=1. Words already written remain in instruction memory.
- Index counter is 16 bits; N is at most 65535.

Test Plan:
- Reset, LOAD_START, stream 00 02 F8 40 01 42 F8 40 11 43 back-to-back -> IMEM_WRITE at addr 0 data F8400142, then at addr 4 data F8401143. WORDS_LOADED=2, LOAD_DONE=1, CPU_HOLD=0, LOAD_ERROR=0.
- Stream 00 00 -> DONE with no IMEM_WRITE, WORDS_LOADED=0, CPU_HOLD falls 1 cycle after the 2nd byte.
- One-word image CB 02 00 64 with BYTE_VALID toggling 1,0,0,1,...: only cycles with VALID&&READY are consumed. Single write of CB020064 at addr 0; no duplicate or dropped bytes.
- MAX_WORDS=2, N=3 with words 8B020065, B4000041, 14000003 -> writes only at addr 0 and 4. Third word consumed without a write. LOAD_ERROR=1, WORDS_LOADED=2, LOAD_DONE=1.
- Assert RESET after the 2nd data byte of word 0 -> CPU_HOLD=1, state IDLE, no IMEM_WRITE. A new LOAD_START with a 1-word image loads cleanly at addr 0.
- From DONE, pulse LOAD_START -> CPU_HOLD=1 and LOAD_DONE=0 on the next edge. A second image with BASE_ADDR=0 rewrites addr 0.
